my_shift_seq: RTL
=================

MY_SHIFT_SEQ -- requirements
Module: my_shift_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of operand and result.
REQ-002 SHALL have parameter AMT_W, default 3, width of shift-amount field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-005 SHALL have port start  input  1  request a shift; sampled only in IDLE.
REQ-006 SHALL have port op1  input  WIDTH  operand, captured when start is accepted.
REQ-007 SHALL have port amt  input  AMT_W  shift count (0..2^AMT_W-1), captured with op1.
REQ-008 SHALL have port dir  input  1  0 = arithmetic shift left, 1 = arithmetic shift right; captured with op1.
REQ-009 SHALL have port out  output  WIDTH  registered result.
REQ-010 SHALL have port cout  output  1  registered last bit shifted out.
REQ-011 SHALL have port zero  output  1  high when out == 0.
REQ-012 SHALL have port busy  output  1  high while in SHIFT state.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse, high while in DONE state.

Function
REQ-014 SHALL implement FSM with states IDLE, SHIFT, DONE.
REQ-015 IDLE: start=1 at edge T SHALL load out<=op1, cout<=0, count<=amt, latch dir; next state SHIFT if amt!=0, else DONE.
REQ-016 IDLE with start=0 SHALL hold out, cout, zero unchanged.
REQ-017 SHIFT, dir=0, each edge: cout<=out[WIDTH-1], out<={out[WIDTH-2:0],1'b0}.
REQ-018 SHIFT, dir=1, each edge: cout<=out[0], out<={out[WIDTH-1],out[WIDTH-1:1]} (sign preserved).
REQ-019 SHIFT SHALL decrement count each edge; the edge on which count==1 SHALL perform the final shift and move to DONE.
REQ-020 Latency: with start accepted at edge T and amt=k, done SHALL rise at edge T+k and fall at edge T+k+1 (k=0: done rises at T, out=op1, cout=0).
REQ-021 DONE SHALL last exactly one cycle then return to IDLE unconditionally.
REQ-022 start while in SHIFT or DONE SHALL be ignored; op1/amt/dir changes after acceptance SHALL not affect the operation.
REQ-023 start asserted in the IDLE cycle directly after DONE SHALL be accepted (back-to-back operations, no gap required).
REQ-024 zero SHALL be combinational from out (out==0) or registered coincident with out; it SHALL never lag out.
REQ-025 out and cout SHALL remain stable from done until the next accepted start.
REQ-026 Shift counts >= WIDTH are legal only when 2^AMT_W > WIDTH; bits SHALL continue shifting (ASHL to 0, ASHR to all-sign).

Reset
REQ-027 rst_n=0 at an edge SHALL force state IDLE, out=0, cout=0, count=0; hence zero=1, busy=0, done=0.
REQ-028 Reset during SHIFT or DONE SHALL abort the operation with no done pulse and no partial result retained.
REQ-029 Reset SHALL take priority over start on the same edge.

Verification
REQ-030 op1=0x0F, amt=1, dir=0 -> out=0x1E, cout=0, done at T+1; op1=0x0F, amt=4 -> out=0xF0, cout=0, done at T+4.
REQ-031 op1=0xF0, amt=5, dir=0 -> out=0x00, cout=0, zero=1; op1=0x81, amt=1 -> out=0x02, cout=1.
REQ-032 op1=0x80, amt=3, dir=1 -> out=0xF0, cout=0; op1=0x03, amt=1, dir=1 -> out=0x01, cout=1.
REQ-033 amt=0, op1=0x5A -> done at edge T, out=0x5A, cout=0, busy never high.
REQ-034 start pulsed with op1=0xFF while busy on amt=7 job -> ignored, original job result unchanged; back-to-back start in cycle after done accepted.
REQ-035 rst_n=0 in mid-SHIFT -> next cycle out=0, cout=0, zero=1, busy=0, no done pulse.

Source files
------------

// File: rtl/my_shift_seq.sv
// Multi-cycle arithmetic shifter: one bit position per clock,
// left or right, with start/busy/done sequencing.
module my_shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [AMT_W-1:0] count;
  logic             dir_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (count == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are latched at acceptance so later input changes are inert.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out   <= '0;
      cout  <= 1'b0;
      count <= '0;
      dir_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            out   <= op1;
            cout  <= 1'b0;
            count <= amt;
            dir_q <= dir;
          end
        end
        SHIFT: begin
          count <= count - AMT_W'(1);
          if (dir_q) begin
            cout <= out[0];
            out  <= {out[WIDTH-1], out[WIDTH-1:1]};
          end else begin
            cout <= out[WIDTH-1];
            out  <= {out[WIDTH-2:0], 1'b0};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign zero = (out == '0);
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule
